// File: rtl/iram_sfr_ctrl.sv
// iram_sfr_ctrl: 8051 internal data memory (lower IRAM, SFR space, bit space) behind a req/rvalid handshake.
// Define UPPER_IRAM_EN to add the 8052 128-byte upper IRAM reached by indirect accesses at 0x80-0xFF.
module iram_sfr_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int IRAM_DEPTH = 128,
  parameter int NUM_PORTS  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   we,
  input  logic                   is_bit,
  input  logic                   indirect,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   wbit,
  input  logic [NUM_PORTS*8-1:0] p_in,
  output logic                   busy,
  output logic                   rvalid,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic                   rbit,
  output logic [NUM_PORTS*8-1:0] p_out
);

  localparam int IW = $clog2(IRAM_DEPTH);
`ifdef UPPER_IRAM_EN
  localparam int CLR_TOTAL = IRAM_DEPTH + 128;
`else
  localparam int CLR_TOTAL = IRAM_DEPTH;
`endif
  localparam int CW = $clog2(CLR_TOTAL + 1);
  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {CLEAR, IDLE, RMW_RD, RMW_WR} state_t;

  function automatic logic port_idx(input logic [6:0] idx);
    return (idx[3:0] == 4'h0) && ({1'b0, idx[6:4]} < 4'(NUM_PORTS));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sfr_reset_val(input logic [6:0] idx);
    logic [DATA_WIDTH-1:0] v;
    if (idx == 7'h01) v = DATA_WIDTH'(8'h07);
    else if (port_idx(idx)) v = DATA_WIDTH'(8'hFF);
    else v = ZERO;
    return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] set_bit(input logic [DATA_WIDTH-1:0] b,
                                                    input logic [2:0] pos, input logic v);
    logic [DATA_WIDTH-1:0] r;
    r = b;
    r[pos] = v;
    return r;
  endfunction

  state_t                state_r, state_nxt_s;
  logic [CW-1:0]         clr_idx_r;
  logic [DATA_WIDTH-1:0] iram [IRAM_DEPTH];
  logic [DATA_WIDTH-1:0] sfr_r [128];
  logic [6:0]            rmw_idx_r;
  logic                  rmw_sfr_r, rmw_wbit_r;
  logic [2:0]            rmw_pos_r;
  logic [DATA_WIDTH-1:0] rmw_byte_r;
  logic                  rvalid_r, rbit_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic [6:0]            dec_idx_s, acc_idx_s;
  logic                  dec_sfr_s, dec_upper_s, acc_sfr_s, acc_upper_s;
  logic [IW-1:0]         iram_idx_s;
  logic [DATA_WIDTH-1:0] upper_rd_s, latch_byte_s, pin_byte_s, port_pin_s, wr_data_s;
  logic                  wr_en_s;

  // Bit addresses below 0x80 live in 0x20-0x2F; above, in the 8-aligned SFR bytes.
  assign dec_idx_s   = !is_bit ? addr[6:0] :
                       (addr[ADDR_WIDTH-1] ? {addr[6:3], 3'b000} : {3'b010, addr[6:3]});
  assign dec_sfr_s   = addr[ADDR_WIDTH-1] & (is_bit | ~indirect);
  assign dec_upper_s = addr[ADDR_WIDTH-1] & ~is_bit & indirect;

  assign acc_idx_s   = (state_r == IDLE) ? dec_idx_s   : rmw_idx_r;
  assign acc_sfr_s   = (state_r == IDLE) ? dec_sfr_s   : rmw_sfr_r;
  assign acc_upper_s = (state_r == IDLE) ? dec_upper_s : 1'b0;
  assign iram_idx_s  = acc_idx_s[IW-1:0];

  // Pin value of the addressed port, used only for reads (RMW uses the latch).
  always_comb begin
    port_pin_s = ZERO;
    for (int k = 0; k < NUM_PORTS; k++) begin
      port_pin_s = (acc_idx_s[6:4] == 3'(k)) ? DATA_WIDTH'(p_in[8*k +: 8]) : port_pin_s;
    end
  end

  assign latch_byte_s = acc_upper_s ? upper_rd_s :
                        (acc_sfr_s ? sfr_r[acc_idx_s] : iram[iram_idx_s]);
  assign pin_byte_s   = (acc_sfr_s && port_idx(acc_idx_s)) ? port_pin_s : latch_byte_s;

  // Next-state and write-port control.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    wr_data_s   = wdata;
    case (state_r)
      CLEAR: begin
        if (clr_idx_r == CW'(CLR_TOTAL - 1)) state_nxt_s = IDLE;
        else state_nxt_s = CLEAR;
      end
      IDLE: begin
        if (req && we && is_bit) begin
          state_nxt_s = RMW_RD;
        end else if (req && we) begin
          wr_en_s   = 1'b1;
          wr_data_s = wdata;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RMW_RD: state_nxt_s = RMW_WR;
      RMW_WR: begin
        state_nxt_s = IDLE;
        wr_en_s     = 1'b1;
        wr_data_s   = set_bit(rmw_byte_r, rmw_pos_r, rmw_wbit_r);
      end
      default: state_nxt_s = CLEAR;
    endcase
  end

  // Control state, RMW context and registered read response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= CLEAR;
      clr_idx_r  <= {CW{1'b0}};
      rmw_idx_r  <= 7'h00;
      rmw_sfr_r  <= 1'b0;
      rmw_pos_r  <= 3'b000;
      rmw_wbit_r <= 1'b0;
      rmw_byte_r <= ZERO;
      rvalid_r   <= 1'b0;
      rdata_r    <= ZERO;
      rbit_r     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rvalid_r <= (state_r == IDLE) && req && !we;
      if (state_r == CLEAR) clr_idx_r <= clr_idx_r + CW'(1);
      if ((state_r == IDLE) && req && !we) begin
        rdata_r <= pin_byte_s;
        if (is_bit) rbit_r <= pin_byte_s[addr[2:0]];
      end
      if ((state_r == IDLE) && req && we && is_bit) begin
        rmw_idx_r  <= dec_idx_s;
        rmw_sfr_r  <= dec_sfr_s;
        rmw_pos_r  <= addr[2:0];
        rmw_wbit_r <= wbit;
      end
      if (state_r == RMW_RD) rmw_byte_r <= latch_byte_s;
    end
  end

  // SFR file; port latches are the SFR bytes at 0x80+16*k.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 128; k++) sfr_r[k] <= sfr_reset_val(7'(k));
    end else if (wr_en_s && acc_sfr_s) begin
      sfr_r[acc_idx_s] <= wr_data_s;
    end
  end

  // Lower IRAM: no reset, zeroed by the CLEAR sweep instead.
  always_ff @(posedge clock) begin
    if (state_r == CLEAR) begin
      if (clr_idx_r < CW'(IRAM_DEPTH)) iram[clr_idx_r[IW-1:0]] <= ZERO;
    end else if (wr_en_s && !acc_sfr_s && !acc_upper_s) begin
      iram[iram_idx_s] <= wr_data_s;
    end
  end

`ifdef UPPER_IRAM_EN
  logic [DATA_WIDTH-1:0] uiram [128];
  logic [6:0]            clr_up_s;
  assign clr_up_s   = 7'(clr_idx_r - CW'(IRAM_DEPTH));
  assign upper_rd_s = uiram[acc_idx_s];

  // Upper IRAM, swept after the lower bytes.
  always_ff @(posedge clock) begin
    if (state_r == CLEAR) begin
      if (clr_idx_r >= CW'(IRAM_DEPTH)) uiram[clr_up_s] <= ZERO;
    end else if (wr_en_s && acc_upper_s) begin
      uiram[acc_idx_s] <= wr_data_s;
    end
  end
`else
  assign upper_rd_s = ZERO;
`endif

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_pout
    assign p_out[8*k +: 8] = sfr_r[16*k][7:0];
  end

  assign busy   = (state_r != IDLE);
  assign rvalid = rvalid_r;
  assign rdata  = rdata_r;
  assign rbit   = rbit_r;

endmodule

// File: tb/tb_iram_sfr_ctrl.sv
// Scoreboard bench for iram_sfr_ctrl: directed accesses push expected read responses,
// a negedge monitor pops and compares them whenever rvalid is seen.
module tb_iram_sfr_ctrl;
  localparam int DEPTH = 128;
`ifdef UPPER_IRAM_EN
  localparam int SWEEP = DEPTH + 128;
  localparam logic [7:0] UP_EXP = 8'h5A;
`else
  localparam int SWEEP = DEPTH;
  localparam logic [7:0] UP_EXP = 8'h00;
`endif

  logic        clk, rst_n, req, we, is_bit, indirect, wbit;
  logic [7:0]  addr, wdata;
  logic [31:0] p_in, p_out;
  logic        busy, rvalid, rbit;
  logic [7:0]  rdata;

  iram_sfr_ctrl dut (
    .clock(clk), .reset(rst_n), .req(req), .we(we), .is_bit(is_bit), .indirect(indirect),
    .addr(addr), .wdata(wdata), .wbit(wbit), .p_in(p_in), .busy(busy), .rvalid(rvalid),
    .rdata(rdata), .rbit(rbit), .p_out(p_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  string      q_nm[$];
  logic [7:0] q_d[$];
  logic       q_b[$];
  logic       q_cb[$];
  int         q_cyc[$];
  int         n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  string      m_nm;
  logic [7:0] m_d;
  logic       m_b, m_cb;
  int         m_cyc;
  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      if (q_d.size() == 0) begin
        chk("unexpected_rvalid", 32'(rvalid), 32'd0);
      end else begin
        m_nm = q_nm.pop_front(); m_d = q_d.pop_front(); m_b = q_b.pop_front();
        m_cb = q_cb.pop_front(); m_cyc = q_cyc.pop_front();
        chk({m_nm, "_latency"}, cyc, m_cyc);
        chk(m_nm, rdata, m_d);
        if (m_cb) chk({m_nm, "_rbit"}, 32'(rbit), 32'(m_b));
      end
    end
  end

  task automatic issue(input logic w, input logic b, input logic ind, input logic [7:0] a,
                       input logic [7:0] d, input logic wb);
    req = 1'b1; we = w; is_bit = b; indirect = ind; addr = a; wdata = d; wbit = wb;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; is_bit = 1'b0; indirect = 1'b0;
  endtask

  task automatic rd(input string nm, input logic b, input logic ind, input logic [7:0] a,
                    input logic [7:0] ed, input logic eb);
    q_nm.push_back(nm); q_d.push_back(ed); q_b.push_back(eb); q_cb.push_back(b);
    q_cyc.push_back(cyc + 1);
    issue(1'b0, b, ind, a, 8'h00, 1'b0);
  endtask

  task automatic wait_idle(input string nm, input int exp_cycles);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 1000);
    chk(nm, n, exp_cycles);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; is_bit = 1'b0; indirect = 1'b0; wbit = 1'b0;
    addr = 8'h00; wdata = 8'h00; p_in = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_pout", p_out, 32'hFFFF_FFFF);
    @(negedge clk); rst_n = 1'b1;
    wait_idle("sweep_len", SWEEP);
    chk("pout_init", p_out, 32'hFFFF_FFFF);
    rd("sp_reset", 1'b0, 1'b0, 8'h81, 8'h07, 1'b0);
    rd("iram30_clr", 1'b0, 1'b0, 8'h30, 8'h00, 1'b0);

    // byte write then back-to-back reads
    issue(1'b1, 1'b0, 1'b0, 8'h3C, 8'hA5, 1'b0);
    rd("rd3c", 1'b0, 1'b0, 8'h3C, 8'hA5, 1'b0);
    rd("b2b_3c", 1'b0, 1'b0, 8'h3C, 8'hA5, 1'b0);
    rd("b2b_3d", 1'b0, 1'b0, 8'h3D, 8'h00, 1'b0);

    // bit write RMW, with requests during busy dropped
    issue(1'b1, 1'b0, 1'b0, 8'h21, 8'h00, 1'b0);
    issue(1'b1, 1'b1, 1'b0, 8'h0B, 8'h00, 1'b1);
    chk("rmw_busy1", 32'(busy), 32'd1);
    issue(1'b1, 1'b0, 1'b0, 8'h22, 8'h77, 1'b0);
    chk("rmw_busy2", 32'(busy), 32'd1);
    issue(1'b0, 1'b0, 1'b0, 8'h21, 8'h00, 1'b0);
    chk("rmw_done", 32'(busy), 32'd0);
    rd("rd21", 1'b0, 1'b0, 8'h21, 8'h08, 1'b0);
    rd("bit0b", 1'b1, 1'b0, 8'h0B, 8'h08, 1'b1);
    rd("drop22", 1'b0, 1'b0, 8'h22, 8'h00, 1'b0);

    // port: reads see pins, RMW sees latch
    p_in = 32'h0000_0F00;
    issue(1'b1, 1'b1, 1'b0, 8'h90, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("p1_bitclr", 32'(p_out[15:8]), 32'h0000_00FE);
    rd("p1_pins", 1'b0, 1'b0, 8'h90, 8'h0F, 1'b0);
    rd("p1_bit1", 1'b1, 1'b0, 8'h91, 8'h0F, 1'b1);
    issue(1'b1, 1'b1, 1'b0, 8'h97, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("p1_rmw_latch", 32'(p_out[15:8]), 32'h0000_007E);

    // indirect vs direct upper space, plain SFRs
    issue(1'b1, 1'b0, 1'b1, 8'h90, 8'h5A, 1'b0);
    chk("ind_no_latch", 32'(p_out[15:8]), 32'h0000_007E);
    rd("ind_rd90", 1'b0, 1'b1, 8'h90, UP_EXP, 1'b0);
    rd("dir_rd90", 1'b0, 1'b0, 8'h90, 8'h0F, 1'b0);
    rd("ind_low3c", 1'b0, 1'b1, 8'h3C, 8'hA5, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 8'hA0, 8'h3C, 1'b0);
    chk("p2_write", 32'(p_out[23:16]), 32'h0000_003C);
    issue(1'b1, 1'b0, 1'b0, 8'hF0, 8'h99, 1'b0);
    rd("sfr_f0", 1'b0, 1'b0, 8'hF0, 8'h99, 1'b0);
    rd("sfr_bit_f3", 1'b1, 1'b0, 8'hF3, 8'h99, 1'b1);

    // reset in the middle of an RMW
    issue(1'b1, 1'b1, 1'b0, 8'h0C, 8'h00, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrmw_busy", 32'(busy), 32'd1);
    chk("midrmw_rvalid", 32'(rvalid), 32'd0);
    chk("midrmw_pout", p_out, 32'hFFFF_FFFF);
    @(negedge clk); rst_n = 1'b1;
    wait_idle("sweep2_len", SWEEP);
    rd("rd21_after", 1'b0, 1'b0, 8'h21, 8'h00, 1'b0);
    rd("rd3c_after", 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0);
    rd("sp_after", 1'b0, 1'b0, 8'h81, 8'h07, 1'b0);
    rd("f0_after", 1'b0, 1'b0, 8'hF0, 8'h00, 1'b0);

    for (int i = 0; i < 10 && q_d.size() != 0; i++) @(posedge clk);
    @(negedge clk); #1;
    chk("sb_drain", q_d.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
